// File: rtl/dct_pkg.sv
// Shared types and constants for the DCT transpose-buffer controllers.
package dct_pkg;

    localparam int DCT_N = 8;

    typedef enum logic {
        RD_IDLE,
        RD_READ
    } rd_state_t;

    typedef logic [DCT_N-1:0] row_sel_t;

endpackage

// File: rtl/dct_onehot_dec.sv
// Index-to-one-hot decoder with enable; also drives the column writer's entry enables.
module dct_onehot_dec
    import dct_pkg::*;
#(
    parameter int N  = DCT_N,
    parameter int CW = $clog2(N)
) (
    input  logic [CW-1:0] idx,
    input  logic          en,
    output logic [N-1:0]  sel
);

    always_comb begin
        sel = '0;
        if (en) begin
            sel[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/dct_stage1_row_rd_ctrl.sv
// Row-read side of the stage-1 transpose buffer: ping-pong bank tracking,
// writer back-pressure and a valid/ready row stream into stage 2.
module dct_stage1_row_rd_ctrl
    import dct_pkg::*;
#(
    parameter int N  = DCT_N,
    parameter int CW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          wr_en_col,
    input  logic          col_done,
    output logic          wr_bank,
    output logic          wr_stall,
    output logic          rd_bank,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [CW-1:0] rd_row,
    output logic [N-1:0]  rd_sel,
    output logic          rd_last,
    output logic          blk_done,
    output logic          err_ovf
);

    logic [1:0] full;
    rd_state_t  state;

    logic       row_is_last;
    logic       handshake;
    logic       last_hs;
    logic       commit;
    logic       ovf_attempt;
    logic [1:0] set_vec;
    logic [1:0] clr_vec;

    // Writer sees only registered occupancy, so wr_stall has no input-to-output path.
    assign wr_stall = full[wr_bank];
    assign rd_last  = rd_valid && row_is_last;

    always_comb begin
        row_is_last = (rd_row == CW'(N - 1));
        handshake   = rd_valid && rd_ready;
        last_hs     = handshake && row_is_last;
        commit      = wr_en_col && col_done && !wr_stall;
        ovf_attempt = wr_en_col && wr_stall;
        set_vec     = '0;
        clr_vec     = '0;
        if (commit) begin
            set_vec[wr_bank] = 1'b1;
        end
        if (last_hs) begin
            clr_vec[rd_bank] = 1'b1;
        end
    end

    dct_onehot_dec #(
        .N  (N),
        .CW (CW)
    ) u_row_dec (
        .idx (rd_row),
        .en  (rd_valid),
        .sel (rd_sel)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            full     <= '0;
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            state    <= RD_IDLE;
            rd_row   <= '0;
            rd_valid <= 1'b0;
            blk_done <= 1'b0;
            err_ovf  <= 1'b0;
        end else if (start) begin
            full     <= '0;
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            state    <= RD_IDLE;
            rd_row   <= '0;
            rd_valid <= 1'b0;
            blk_done <= 1'b0;
        end else begin
            // Clear beats set on a same-bank collision; the collision itself is an overflow.
            full     <= (full | set_vec) & ~clr_vec;
            blk_done <= last_hs;
            if (commit) begin
                wr_bank <= ~wr_bank;
            end
            if (ovf_attempt || (|(set_vec & clr_vec))) begin
                err_ovf <= 1'b1;
            end
            case (state)
                RD_IDLE: begin
                    if (full[rd_bank]) begin
                        state    <= RD_READ;
                        rd_row   <= '0;
                        rd_valid <= 1'b1;
                    end
                end
                RD_READ: begin
                    if (handshake) begin
                        if (row_is_last) begin
                            rd_row  <= '0;
                            rd_bank <= ~rd_bank;
                            // Other bank already loaded: continue without a bubble.
                            if (!full[~rd_bank]) begin
                                state    <= RD_IDLE;
                                rd_valid <= 1'b0;
                            end
                        end else begin
                            rd_row <= rd_row + CW'(1);
                        end
                    end
                end
                default: begin
                    state    <= RD_IDLE;
                    rd_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dct_stage1_row_rd_ctrl.sv
// Scoreboard bench: committed blocks push their expected rows, the monitor pops them on each handshake.
module tb_dct_stage1_row_rd_ctrl;

    localparam int N  = 8;
    localparam int CW = 3;

    logic          clk       = 1'b0;
    logic          rst       = 1'b0;
    logic          start     = 1'b0;
    logic          wr_en_col = 1'b0;
    logic          col_done  = 1'b0;
    logic          rd_ready  = 1'b0;
    logic          wr_bank;
    logic          wr_stall;
    logic          rd_bank;
    logic          rd_valid;
    logic [CW-1:0] rd_row;
    logic [N-1:0]  rd_sel;
    logic          rd_last;
    logic          blk_done;
    logic          err_ovf;

    typedef struct packed {
        logic          bank;
        logic [CW-1:0] row;
    } exp_t;

    exp_t sb[$];

    int   n_pass    = 0;
    int   n_total   = 0;
    int   hs_cnt    = 0;
    int   blk_cnt   = 0;
    int   hold_cnt  = 0;
    int   rdy_mode  = 0;
    int   rdy_cyc   = 0;
    bit   mon_en    = 1'b0;
    logic mwb       = 1'b0;
    logic ovf_exp   = 1'b0;

    bit            prev_hold = 1'b0;
    bit            prev_last = 1'b0;
    logic [CW-1:0] h_row;
    logic          h_bank;
    logic [N-1:0]  h_sel;
    exp_t          m_e;
    logic [N-1:0]  m_sel;

    dct_stage1_row_rd_ctrl #(.N(N), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .wr_en_col (wr_en_col),
        .col_done  (col_done),
        .wr_bank   (wr_bank),
        .wr_stall  (wr_stall),
        .rd_bank   (rd_bank),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_row    (rd_row),
        .rd_sel    (rd_sel),
        .rd_last   (rd_last),
        .blk_done  (blk_done),
        .err_ovf   (err_ovf)
    );

    always #5 clk = ~clk;

    // rd_ready pattern: 0 = always ready, 1 = 1,0,0 repeating, 2 = never ready.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       rd_ready = 1'b1;
            1:       rd_ready = ((rdy_cyc % 3) == 0);
            default: rd_ready = 1'b0;
        endcase
        rdy_cyc++;
    end

    // Scoreboard monitor: handshake order, hold rules, idle outputs and blk_done timing.
    always @(negedge clk) begin
        if (mon_en) begin
            n_total++;
            if (blk_done !== prev_last) begin
                $display("[TB] FAIL blk_done_timing: got %b expected %b", blk_done, prev_last);
            end else begin
                n_pass++;
            end
            if (blk_done === 1'b1) blk_cnt++;
            if (prev_hold) begin
                hold_cnt++;
                n_total++;
                if (rd_valid !== 1'b1 || rd_row !== h_row || rd_bank !== h_bank || rd_sel !== h_sel) begin
                    $display("[TB] FAIL hold: got v=%b row=%0d bank=%b sel=%h expected v=1 row=%0d bank=%b sel=%h",
                             rd_valid, rd_row, rd_bank, rd_sel, h_row, h_bank, h_sel);
                end else begin
                    n_pass++;
                end
            end
            if (rd_valid === 1'b0) begin
                n_total++;
                if (rd_sel !== '0 || rd_last !== 1'b0) begin
                    $display("[TB] FAIL idle_outputs: got sel=%h last=%b expected sel=0 last=0", rd_sel, rd_last);
                end else begin
                    n_pass++;
                end
            end
            prev_last = 1'b0;
            if (rd_valid === 1'b1 && rd_ready === 1'b1) begin
                hs_cnt++;
                n_total++;
                if (sb.size() == 0) begin
                    $display("[TB] FAIL unexpected_row: got row=%0d bank=%b expected no handshake", rd_row, rd_bank);
                end else begin
                    m_e   = sb.pop_front();
                    m_sel = '0;
                    m_sel[m_e.row] = 1'b1;
                    prev_last = (m_e.row == CW'(N - 1));
                    if (rd_bank !== m_e.bank || rd_row !== m_e.row || rd_sel !== m_sel || rd_last !== prev_last) begin
                        $display("[TB] FAIL row_data: got bank=%b row=%0d sel=%h last=%b expected bank=%b row=%0d sel=%h last=%b",
                                 rd_bank, rd_row, rd_sel, rd_last, m_e.bank, m_e.row, m_sel, prev_last);
                    end else begin
                        n_pass++;
                    end
                end
            end
            prev_hold = (rd_valid === 1'b1 && rd_ready === 1'b0);
            h_row     = rd_row;
            h_bank    = rd_bank;
            h_sel     = rd_sel;
        end else begin
            prev_hold = 1'b0;
            prev_last = 1'b0;
        end
    end

    task automatic write_block();
        exp_t e;
        for (int i = 0; i < N; i++) begin
            wr_en_col = 1'b1;
            col_done  = (i == N - 1);
            if (i == N - 1) begin
                for (int r = 0; r < N; r++) begin
                    e.bank = mwb;
                    e.row  = CW'(r);
                    sb.push_back(e);
                end
                mwb = ~mwb;
            end
            @(posedge clk); #1;
        end
        wr_en_col = 1'b0;
        col_done  = 1'b0;
    endtask

    task automatic overflow_pulse();
        wr_en_col = 1'b1;
        col_done  = 1'b1;
        @(posedge clk); #1;
        wr_en_col = 1'b0;
        col_done  = 1'b0;
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk); #1;
            if (sb.size() == 0 && rd_valid === 1'b0 && blk_done === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [N+CW+7:0] got;
        mon_en = 1'b0;
        rst    = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        got = {wr_bank, wr_stall, rd_bank, rd_valid, rd_row, rd_sel, rd_last, blk_done, err_ovf};
        n_total++;
        if (got !== '0) begin
            $display("[TB] FAIL reset_state: got %h expected 0", got);
        end else begin
            n_pass++;
        end
        #1 mon_en = 1'b1;
    endtask

    task automatic test_single();
        int blk0;
        rdy_mode = 0;
        blk0     = blk_cnt;
        write_block();
        @(negedge clk);
        n_total++;
        if (rd_valid !== 1'b0 || wr_bank !== 1'b1) begin
            $display("[TB] FAIL single_latency: got valid=%b wr_bank=%b expected valid=0 wr_bank=1", rd_valid, wr_bank);
        end else begin
            n_pass++;
        end
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            n_total++;
            if (rd_valid !== 1'b1 || rd_row !== CW'(i) || rd_last !== (i == N - 1)) begin
                $display("[TB] FAIL single_row%0d: got valid=%b row=%0d last=%b expected valid=1 row=%0d last=%b",
                         i, rd_valid, rd_row, rd_last, i, (i == N - 1));
            end else begin
                n_pass++;
            end
        end
        @(negedge clk);
        n_total++;
        if (blk_done !== 1'b1 || rd_valid !== 1'b0 || rd_bank !== 1'b1 || wr_stall !== 1'b0) begin
            $display("[TB] FAIL single_end: got blk=%b valid=%b rd_bank=%b stall=%b expected blk=1 valid=0 rd_bank=1 stall=0",
                     blk_done, rd_valid, rd_bank, wr_stall);
        end else begin
            n_pass++;
        end
        repeat (3) @(negedge clk);
        n_total++;
        if (rd_valid !== 1'b0 || blk_cnt - blk0 !== 1) begin
            $display("[TB] FAIL single_empty: got valid=%b blocks=%0d expected valid=0 blocks=1", rd_valid, blk_cnt - blk0);
        end else begin
            n_pass++;
        end
    endtask

    task automatic test_backpressure();
        int hs0, blk0, hold0;
        bit ok;
        rdy_mode = 1;
        hs0      = hs_cnt;
        blk0     = blk_cnt;
        hold0    = hold_cnt;
        write_block();
        wait_drain(200, ok);
        n_total++;
        if (!ok) begin
            $display("[TB] FAIL bp_drain: got queue=%0d valid=%b expected queue=0 valid=0 within 200 cycles", sb.size(), rd_valid);
        end else begin
            n_pass++;
        end
        n_total++;
        if (hs_cnt - hs0 !== N || blk_cnt - blk0 !== 1 || hold_cnt - hold0 < 1 || rd_bank !== mwb) begin
            $display("[TB] FAIL bp_counts: got hs=%0d blk=%0d holds=%0d rd_bank=%b expected hs=8 blk=1 holds>=1 rd_bank=%b",
                     hs_cnt - hs0, blk_cnt - blk0, hold_cnt - hold0, rd_bank, mwb);
        end else begin
            n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int   hs0, blk0;
        logic fb;
        bit   seen, ok;
        rdy_mode = 1;
        hs0      = hs_cnt;
        blk0     = blk_cnt;
        fb       = mwb;
        seen     = 1'b0;
        write_block();
        write_block();
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (blk_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        n_total++;
        if (!seen || rd_valid !== 1'b1 || rd_bank !== ~fb || rd_row !== '0) begin
            $display("[TB] FAIL pingpong_no_bubble: got seen=%b valid=%b bank=%b row=%0d expected seen=1 valid=1 bank=%b row=0",
                     seen, rd_valid, rd_bank, rd_row, ~fb);
        end else begin
            n_pass++;
        end
        wait_drain(300, ok);
        n_total++;
        if (!ok || hs_cnt - hs0 !== 2 * N || blk_cnt - blk0 !== 2) begin
            $display("[TB] FAIL pingpong_counts: got drained=%b hs=%0d blk=%0d expected drained=1 hs=16 blk=2",
                     ok, hs_cnt - hs0, blk_cnt - blk0);
        end else begin
            n_pass++;
        end
    endtask

    task automatic test_overflow();
        int  blk0;
        bit  seen, ok;
        rdy_mode = 2;
        blk0     = blk_cnt;
        seen     = 1'b0;
        write_block();
        write_block();
        repeat (3) @(negedge clk);
        n_total++;
        if (wr_stall !== 1'b1 || err_ovf !== 1'b0 || rd_valid !== 1'b1 || wr_bank !== mwb) begin
            $display("[TB] FAIL ovf_full: got stall=%b err=%b valid=%b wr_bank=%b expected stall=1 err=0 valid=1 wr_bank=%b",
                     wr_stall, err_ovf, rd_valid, wr_bank, mwb);
        end else begin
            n_pass++;
        end
        overflow_pulse();
        ovf_exp = 1'b1;
        @(negedge clk);
        n_total++;
        if (err_ovf !== 1'b1 || wr_bank !== mwb || wr_stall !== 1'b1) begin
            $display("[TB] FAIL ovf_flag: got err=%b wr_bank=%b stall=%b expected err=1 wr_bank=%b stall=1",
                     err_ovf, wr_bank, wr_stall, mwb);
        end else begin
            n_pass++;
        end
        rdy_mode = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (blk_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        n_total++;
        if (!seen || wr_stall !== 1'b0 || rd_valid !== 1'b1) begin
            $display("[TB] FAIL ovf_release: got seen=%b stall=%b valid=%b expected seen=1 stall=0 valid=1",
                     seen, wr_stall, rd_valid);
        end else begin
            n_pass++;
        end
        wait_drain(100, ok);
        n_total++;
        if (!ok || blk_cnt - blk0 !== 2 || err_ovf !== 1'b1) begin
            $display("[TB] FAIL ovf_drain: got drained=%b blk=%0d err=%b expected drained=1 blk=2 err=1",
                     ok, blk_cnt - blk0, err_ovf);
        end else begin
            n_pass++;
        end
    endtask

    task automatic test_abort();
        bit seen, ok;
        rdy_mode = 0;
        seen     = 1'b0;
        write_block();
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (rd_valid === 1'b1 && rd_row === CW'(3)) begin
                seen = 1'b1;
                break;
            end
        end
        mon_en = 1'b0;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        sb.delete();
        mwb = 1'b0;
        @(negedge clk);
        n_total++;
        if (!seen || rd_valid !== 1'b0 || rd_sel !== '0 || wr_bank !== 1'b0 || rd_bank !== 1'b0 ||
            wr_stall !== 1'b0 || err_ovf !== ovf_exp) begin
            $display("[TB] FAIL abort_state: got seen=%b valid=%b sel=%h wr_bank=%b rd_bank=%b stall=%b err=%b expected seen=1 valid=0 sel=0 banks=0 stall=0 err=%b",
                     seen, rd_valid, rd_sel, wr_bank, rd_bank, wr_stall, err_ovf, ovf_exp);
        end else begin
            n_pass++;
        end
        repeat (3) @(negedge clk);
        n_total++;
        if (rd_valid !== 1'b0) begin
            $display("[TB] FAIL abort_empty: got valid=%b expected 0", rd_valid);
        end else begin
            n_pass++;
        end
        #1 mon_en = 1'b1;
        write_block();
        wait_drain(100, ok);
        n_total++;
        if (!ok || rd_bank !== mwb) begin
            $display("[TB] FAIL abort_refill: got drained=%b rd_bank=%b expected drained=1 rd_bank=%b", ok, rd_bank, mwb);
        end else begin
            n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        logic [N+CW+7:0] got;
        rdy_mode = 2;
        write_block();
        write_block();
        overflow_pulse();
        @(negedge clk);
        n_total++;
        if (err_ovf !== 1'b1 || wr_stall !== 1'b1) begin
            $display("[TB] FAIL rstmid_setup: got err=%b stall=%b expected err=1 stall=1", err_ovf, wr_stall);
        end else begin
            n_pass++;
        end
        mon_en = 1'b0;
        rst    = 1'b1;
        @(posedge clk); #1;
        rst      = 1'b0;
        rdy_mode = 0;
        sb.delete();
        mwb     = 1'b0;
        ovf_exp = 1'b0;
        @(negedge clk);
        got = {wr_bank, wr_stall, rd_bank, rd_valid, rd_row, rd_sel, rd_last, blk_done, err_ovf};
        n_total++;
        if (got !== '0) begin
            $display("[TB] FAIL rstmid_state: got %h expected 0", got);
        end else begin
            n_pass++;
        end
        repeat (3) @(negedge clk);
        n_total++;
        if (rd_valid !== 1'b0 || err_ovf !== 1'b0) begin
            $display("[TB] FAIL rstmid_empty: got valid=%b err=%b expected valid=0 err=0", rd_valid, err_ovf);
        end else begin
            n_pass++;
        end
        #1 mon_en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_overflow();
        test_abort();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
